// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller. It stalls, bubbles and flushes the five-stage pipeline for
// load-use hazards, slow data-memory accesses and taken branches, and has a memory watchdog.
//
// state     | meaning
// ----------+----------------------------------------------------------------
// RUN       | normal flow, no memory access outstanding across an edge
// MEM_WAIT  | data memory has stalled for wait_cnt consecutive edges
// ERROR     | memory never answered, pipeline frozen until reset
module hazard_stall_unit #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       IF_ID_Rs1,
   input  logic [4:0]       IF_ID_Rs2,
   input  logic             IF_ID_UsesRs1,
   input  logic             IF_ID_UsesRs2,
   input  logic [4:0]       ID_EX_Rd,
   input  logic             ID_EX_MemRead,
   input  logic             EX_MEM_MemAccess,
   input  logic             mem_ready,
   input  logic             branch_taken,
   output logic             PC_Write,
   output logic             IF_ID_Write,
   output logic             ID_EX_Write,
   output logic             EX_MEM_Write,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Flush,
   output logic             MEM_WB_Bubble,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ERROR    = 2'd2
   } state_t;

   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] wait_cnt;
   logic [7:0] wait_cnt_nxt;

   logic rs1_hit;
   logic rs2_hit;
   logic load_use;
   logic mem_stall;
   logic stall_inc;
   logic flush_inc;

   assign rs1_hit   = IF_ID_UsesRs1 && (ID_EX_Rd == IF_ID_Rs1);
   assign rs2_hit   = IF_ID_UsesRs2 && (ID_EX_Rd == IF_ID_Rs2);
   assign load_use  = ID_EX_MemRead && (ID_EX_Rd != 5'd0) && (rs1_hit || rs2_hit);
   assign mem_stall = EX_MEM_MemAccess && !mem_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_RUN;
         wait_cnt <= 8'd0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      case (state)
         ST_RUN: begin
            if (mem_stall) begin
               state_nxt    = ST_MEM_WAIT;
               wait_cnt_nxt = 8'd1;
            end
         end
         ST_MEM_WAIT: begin
            if (!mem_stall) begin
               state_nxt    = ST_RUN;
               wait_cnt_nxt = 8'd0;
            end else if (wait_cnt == WAIT_LAST) begin
               state_nxt = ST_ERROR;
            end else begin
               wait_cnt_nxt = wait_cnt + 8'd1;
            end
         end
         ST_ERROR: begin
            state_nxt = ST_ERROR;
         end
         default: begin
            state_nxt    = ST_RUN;
            wait_cnt_nxt = 8'd0;
         end
      endcase
   end

   // A branch seen during a memory stall is simply not acted on; it is still in EX when the stall ends.
   always_comb begin
      PC_Write      = 1'b1;
      IF_ID_Write   = 1'b1;
      ID_EX_Write   = 1'b1;
      EX_MEM_Write  = 1'b1;
      IF_ID_Flush   = 1'b0;
      ID_EX_Flush   = 1'b0;
      MEM_WB_Bubble = 1'b0;
      mem_timeout   = (state == ST_ERROR);
      if (state == ST_ERROR || mem_stall) begin
         PC_Write      = 1'b0;
         IF_ID_Write   = 1'b0;
         ID_EX_Write   = 1'b0;
         EX_MEM_Write  = 1'b0;
         MEM_WB_Bubble = 1'b1;
      end else if (branch_taken) begin
         IF_ID_Flush = 1'b1;
         ID_EX_Flush = 1'b1;
      end else if (load_use) begin
         PC_Write    = 1'b0;
         IF_ID_Write = 1'b0;
         ID_EX_Flush = 1'b1;
      end
   end

   assign stall_inc = !PC_Write && (state != ST_ERROR);
   assign flush_inc = IF_ID_Flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         if (stall_inc && (stall_cycles != '1))
            stall_cycles <= stall_cycles + CNT_W'(1);
         if (flush_inc && (flush_events != '1))
            flush_events <= flush_events + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: directed hazard scenarios followed by random traffic,
// checked against a reference model of the pipeline-control rules.
module tb_hazard_stall_unit;

   localparam int MT = 4;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] rd;
      logic       memread;
      logic       memacc;
      logic       ready;
      logic       br;
   } stim_t;

   typedef struct packed {
      logic [6:0]    ctrl;
      logic          tmo;
      logic [CW-1:0] sc;
      logic [CW-1:0] fe;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic [4:0]    IF_ID_Rs1, IF_ID_Rs2, ID_EX_Rd;
   logic          IF_ID_UsesRs1, IF_ID_UsesRs2, ID_EX_MemRead;
   logic          EX_MEM_MemAccess, mem_ready, branch_taken;
   logic          PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write;
   logic          IF_ID_Flush, ID_EX_Flush, MEM_WB_Bubble, mem_timeout;
   logic [CW-1:0] stall_cycles, flush_events;

   hazard_stall_unit #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .IF_ID_Rs1        (IF_ID_Rs1),
      .IF_ID_Rs2        (IF_ID_Rs2),
      .IF_ID_UsesRs1    (IF_ID_UsesRs1),
      .IF_ID_UsesRs2    (IF_ID_UsesRs2),
      .ID_EX_Rd         (ID_EX_Rd),
      .ID_EX_MemRead    (ID_EX_MemRead),
      .EX_MEM_MemAccess (EX_MEM_MemAccess),
      .mem_ready        (mem_ready),
      .branch_taken     (branch_taken),
      .PC_Write         (PC_Write),
      .IF_ID_Write      (IF_ID_Write),
      .ID_EX_Write      (ID_EX_Write),
      .EX_MEM_Write     (EX_MEM_Write),
      .IF_ID_Flush      (IF_ID_Flush),
      .ID_EX_Flush      (ID_EX_Flush),
      .MEM_WB_Bubble    (MEM_WB_Bubble),
      .mem_timeout      (mem_timeout),
      .stall_cycles     (stall_cycles),
      .flush_events     (flush_events)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t exp_q[$];

   // reference model: error flag, run length of stalled edges, and the two event tallies
   bit m_err;
   int m_run;
   int m_stall;
   int m_flush;

   // control vector order: {PC, IF_ID_W, ID_EX_W, EX_MEM_W, IF_ID_F, ID_EX_F, MEM_WB_Bubble}
   function automatic logic [6:0] exp_ctrl(input stim_t s, input bit err);
      bit lu;
      bit ms;
      lu = s.memread && (s.rd != 5'd0) &&
           ((s.u1 && s.rd == s.rs1) || (s.u2 && s.rd == s.rs2));
      ms = s.memacc && !s.ready;
      if (err || ms) return 7'b0000001;
      if (s.br)      return 7'b1111110;
      if (lu)        return 7'b0011010;
      return 7'b1111000;
   endfunction

   task automatic model_reset();
      m_err   = 1'b0;
      m_run   = 0;
      m_stall = 0;
      m_flush = 0;
   endtask

   task automatic model_edge(input stim_t s);
      logic [6:0] c;
      c = exp_ctrl(s, m_err);
      if (!c[6] && !m_err && m_stall < CMAX) m_stall++;
      if (c[2] && m_flush < CMAX) m_flush++;
      if (!m_err) begin
         if (s.memacc && !s.ready) begin
            m_run++;
            if (m_run >= MT) m_err = 1'b1;
         end else begin
            m_run = 0;
         end
      end
   endtask

   task automatic cycle(input stim_t s, input logic rst);
      exp_t e;
      @(negedge clk);
      rst_n            = rst;
      IF_ID_Rs1        = s.rs1;
      IF_ID_Rs2        = s.rs2;
      IF_ID_UsesRs1    = s.u1;
      IF_ID_UsesRs2    = s.u2;
      ID_EX_Rd         = s.rd;
      ID_EX_MemRead    = s.memread;
      EX_MEM_MemAccess = s.memacc;
      mem_ready        = s.ready;
      branch_taken     = s.br;
      if (!rst) model_reset();
      e.ctrl = exp_ctrl(s, m_err);
      e.tmo  = m_err;
      e.sc   = CW'(m_stall);
      e.fe   = CW'(m_flush);
      exp_q.push_back(e);
      if (rst) model_edge(s);
   endtask

   initial begin
      exp_t       e;
      logic [6:0] act;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
                   IF_ID_Flush, ID_EX_Flush, MEM_WB_Bubble};
            n_checks += 4;
            if (act !== e.ctrl) begin
               n_fail++;
               $display("FAIL ctrl t=%0t actual=%b required=%b", $time, act, e.ctrl);
            end
            if (mem_timeout !== e.tmo) begin
               n_fail++;
               $display("FAIL mem_timeout t=%0t actual=%b required=%b", $time, mem_timeout, e.tmo);
            end
            if (stall_cycles !== e.sc) begin
               n_fail++;
               $display("FAIL stall_cycles t=%0t actual=%0d required=%0d", $time, stall_cycles, e.sc);
            end
            if (flush_events !== e.fe) begin
               n_fail++;
               $display("FAIL flush_events t=%0t actual=%0d required=%0d", $time, flush_events, e.fe);
            end
         end
      end
   end

   initial begin
      stim_t idle;
      stim_t s;
      idle = '0;
      rst_n = 1'b0;
      {IF_ID_Rs1, IF_ID_Rs2, ID_EX_Rd} = '0;
      {IF_ID_UsesRs1, IF_ID_UsesRs2, ID_EX_MemRead} = '0;
      {EX_MEM_MemAccess, mem_ready, branch_taken} = '0;
      model_reset();

      cycle(idle, 1'b0);
      cycle(idle, 1'b0);
      cycle(idle, 1'b1);

      // load-use: one stalled cycle, then the bubble (Rd=0) lets it go
      s = idle; s.memread = 1; s.rd = 5; s.rs1 = 5; s.u1 = 1;
      cycle(s, 1'b1);
      s.rd = 0; s.memread = 0;
      cycle(s, 1'b1);
      s = idle; s.memread = 1; s.rd = 0; s.rs1 = 0; s.u1 = 1;
      cycle(s, 1'b1);
      s = idle; s.memread = 1; s.rd = 7; s.rs2 = 7; s.u2 = 1;
      cycle(s, 1'b1);
      cycle(idle, 1'b1);

      // three-cycle memory stall then release
      s = idle; s.memacc = 1; s.ready = 0;
      repeat (3) cycle(s, 1'b1);
      s.ready = 1;
      cycle(s, 1'b1);
      cycle(idle, 1'b1);

      // branch together with load-use
      s = idle; s.memread = 1; s.rd = 3; s.rs1 = 3; s.u1 = 1; s.br = 1;
      cycle(s, 1'b1);
      cycle(idle, 1'b1);

      // branch deferred by a two-cycle memory stall
      s = idle; s.memacc = 1; s.ready = 0; s.br = 1;
      repeat (2) cycle(s, 1'b1);
      s.ready = 1;
      cycle(s, 1'b1);
      cycle(idle, 1'b1);

      // watchdog: stall past the limit, dropping the access does not clear the error
      s = idle; s.memacc = 1; s.ready = 0;
      repeat (6) cycle(s, 1'b1);
      s = idle; s.br = 1; s.memread = 1; s.rd = 2; s.rs1 = 2; s.u1 = 1;
      repeat (3) cycle(s, 1'b1);
      cycle(idle, 1'b0);
      cycle(idle, 1'b1);

      // a stall run one short of the limit still recovers
      s = idle; s.memacc = 1; s.ready = 0;
      repeat (MT - 1) cycle(s, 1'b1);
      cycle(idle, 1'b1);

      // saturate the stall counter with twenty load-use stalls
      repeat (20) begin
         s = idle; s.memread = 1; s.rd = 9; s.rs1 = 9; s.u1 = 1;
         cycle(s, 1'b1);
         cycle(idle, 1'b1);
      end

      // reset in the middle of a memory stall
      s = idle; s.memacc = 1; s.ready = 0;
      repeat (2) cycle(s, 1'b1);
      cycle(s, 1'b0);
      cycle(idle, 1'b1);

      for (int i = 0; i < 1500; i++) begin
         s.rs1     = 5'($urandom_range(0, 3));
         s.rs2     = 5'($urandom_range(0, 3));
         s.rd      = 5'($urandom_range(0, 3));
         s.u1      = 1'($urandom_range(0, 1));
         s.u2      = 1'($urandom_range(0, 1));
         s.memread = 1'($urandom_range(0, 1));
         s.memacc  = ($urandom_range(0, 2) == 0);
         s.ready   = ($urandom_range(0, 2) != 0);
         s.br      = ($urandom_range(0, 5) == 0);
         cycle(s, ($urandom_range(0, 39) != 0));
      end

      repeat (3) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
